// File: rtl/uart_pkg.sv
// Shared UART framing constants and the TX framer state encoding.
// The inbound command arbiter imports the same values.
package uart_pkg;

  localparam logic [7:0] HDR_DC = 8'h00;

  localparam int DC_BYTES_DEF     = 124;
  localparam int LAUNCH_BYTES_DEF = 3;
  localparam int NUM_DC_CHANNEL   = DC_BYTES_DEF / 4;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAYLOAD
  } state_t;

endpackage

// File: rtl/uart_tx_framer.sv
// Serializes a header byte plus a captured register snapshot into the
// UART TX byte queue, header first, then payload high byte to low byte.
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int DC_BYTES     = DC_BYTES_DEF,
  parameter int LAUNCH_BYTES = LAUNCH_BYTES_DEF
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_req_valid,
  output logic                          o_req_ready,
  input  logic [7:0]                    i_req_hdr,
  input  logic [DC_BYTES/4-1:0][31:0]   i_req_regs,
  output logic                          o_enq_txq,
  input  logic                          i_txq_full,
  output logic [7:0]                    o_txq_data,
  output logic                          o_frame_done,
  output logic                          o_busy
);

  localparam int NW = DC_BYTES / 4;
  localparam int CW = $clog2(DC_BYTES);

  localparam logic [CW-1:0] DC_LAST = CW'(DC_BYTES - 1);
  localparam logic [CW-1:0] LA_LAST = CW'(LAUNCH_BYTES - 1);

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [7:0]            r_hdr;
  logic [NW-1:0][31:0]   r_regs;

  logic [DC_BYTES-1:0][7:0] w_bytes;
  logic [7:0]               w_pay;
  logic                     w_push;

  // Word-packed snapshot viewed as a flat byte array: byte k = word k/4, lane k%4.
  assign w_bytes = r_regs;
  assign w_pay   = w_bytes[r_cnt];
  assign w_push  = (r_state != IDLE) && !i_txq_full;

  assign o_req_ready  = (r_state == IDLE);
  assign o_busy       = (r_state != IDLE);
  assign o_enq_txq    = w_push;
  assign o_txq_data   = (r_state == PAYLOAD) ? w_pay : r_hdr;
  assign o_frame_done = w_push && (r_state == PAYLOAD) && (r_cnt == '0);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_hdr   <= '0;
      r_regs  <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (i_req_valid) begin
            r_hdr   <= i_req_hdr;
            r_regs  <= i_req_regs;
            r_state <= HDR;
          end
        end
        HDR: begin
          if (w_push) begin
            r_cnt   <= (r_hdr == HDR_DC) ? DC_LAST : LA_LAST;
            r_state <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (w_push) begin
            if (r_cnt == '0) r_state <= IDLE;
            else             r_cnt   <= r_cnt - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
